fp8div_seq: RTL and testbench

//  Sequential FP8 divider: result = a / b, in the same 1-4-3 format (sign, exp[3:0], mant[2:0]) that fp8mul produces.
//  One restoring-division quotient bit per cycle.

---
 rtl/fp8div_seq.sv | 168 ++++++++++++++++
 tb/tb_fp8div_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fp8div_seq.sv
// Sequential FP8 (1-4-3) divider: restoring division producing one quotient bit per
// cycle, round-to-nearest-even, valid/ready handshake on operand and result sides.
module fp8div_seq #(
    parameter int EXP_BIAS     = 7,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t      state_reg;
    logic        sign_reg;
    logic [3:0]  ea_reg;
    logic [3:0]  eb_reg;
    logic [2:0]  mb_reg;
    logic [4:0]  rem_reg;
    logic [6:0]  q_reg;
    logic [2:0]  cnt_reg;
    logic        special_reg;
    logic [7:0]  special_res_reg;
    logic [7:0]  result_reg;
    logic        out_valid_reg;
    logic        in_ready_reg;
    logic        busy_reg;

    // Operand classification at accept time; 0x80 is the only NaN encoding.
    logic a_nan, b_nan, a_zero, b_zero, spec_hit;
    logic [7:0] spec_val;

    always_comb begin
        a_nan    = (a == 8'h80);
        b_nan    = (b == 8'h80);
        a_zero   = (a[6:3] == 4'd0) && !a_nan;
        b_zero   = (b[6:3] == 4'd0) && !b_nan;
        spec_hit = a_nan || b_nan || b_zero || a_zero;
        spec_val = (a_nan || b_nan || b_zero) ? 8'h80 : 8'h00;
    end

    // Restoring step; the remainder register holds the already-shifted remainder,
    // so after the last step it is 2*R, which is nonzero exactly when R is.
    logic [4:0] d_val;
    logic       q_bit;
    logic [4:0] sub_val;
    logic [4:0] rem_shift;

    always_comb begin
        d_val     = {2'b01, mb_reg};
        q_bit     = (rem_reg >= d_val);
        sub_val   = q_bit ? (rem_reg - d_val) : rem_reg;
        rem_shift = sub_val << 1;
    end

    logic [2:0]         mant;
    logic               guard_bit;
    logic               sticky;
    logic               adj;
    logic               inc;
    logic [3:0]         mant_sum;
    logic [5:0]         e_full;
    logic signed [5:0]  e_s;
    logic [7:0]         round_res;

    always_comb begin
        if (q_reg[6]) begin
            mant      = q_reg[5:3];
            guard_bit = q_reg[2];
            sticky    = (|q_reg[1:0]) || (rem_reg != 5'd0);
            adj       = 1'b0;
        end else begin
            mant      = q_reg[4:2];
            guard_bit = q_reg[1];
            sticky    = q_reg[0] || (rem_reg != 5'd0);
            adj       = 1'b1;
        end
        inc      = guard_bit && (sticky || mant[0]);
        mant_sum = {1'b0, mant} + {3'b000, inc};
        e_full   = {2'b00, ea_reg} - {2'b00, eb_reg} + 6'(EXP_BIAS)
                   - {5'b00000, adj} + {5'b00000, mant_sum[3]};
        e_s      = $signed(e_full);
        if (e_s > 6'sd15)
            round_res = {sign_reg, 4'hF, 3'h7};
        else if (e_s <= 6'sd0)
            round_res = 8'h00;
        else
            round_res = {sign_reg, e_full[3:0], mant_sum[2:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            sign_reg        <= 1'b0;
            ea_reg          <= 4'd0;
            eb_reg          <= 4'd0;
            mb_reg          <= 3'd0;
            rem_reg         <= 5'd0;
            q_reg           <= 7'd0;
            cnt_reg         <= 3'd0;
            special_reg     <= 1'b0;
            special_res_reg <= 8'h00;
            result_reg      <= 8'h00;
            out_valid_reg   <= 1'b0;
            in_ready_reg    <= 1'b1;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg        <= a[7] ^ b[7];
                        ea_reg          <= a[6:3];
                        eb_reg          <= b[6:3];
                        mb_reg          <= b[2:0];
                        rem_reg         <= {2'b01, a[2:0]};
                        q_reg           <= 7'd0;
                        cnt_reg         <= 3'd0;
                        special_reg     <= spec_hit;
                        special_res_reg <= spec_val;
                        in_ready_reg    <= 1'b0;
                        if (spec_hit && FAST_SPECIAL) begin
                            state_reg     <= DONE;
                            result_reg    <= spec_val;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= DIV;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    q_reg   <= {q_reg[5:0], q_bit};
                    rem_reg <= rem_shift;
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd6)
                        state_reg <= ROUND;
                end
                ROUND: begin
                    state_reg     <= DONE;
                    busy_reg      <= 1'b0;
                    out_valid_reg <= 1'b1;
                    result_reg    <= special_reg ? special_res_reg : round_res;
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_fp8div_seq.sv
// Directed bench for fp8div_seq: hand-computed quotients, latency, handshake hold and reset abort.
module tb_fp8div_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    fp8div_seq #(.EXP_BIAS(7), .FAST_SPECIAL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Presents one operand pair, checks latency, busy profile and result.
    // keep: leave in_valid high after accept; consume: complete the handshake.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [7:0] expv, input int exp_lat,
                          input bit keep, input bit consume);
        int n;
        int lat;
        int busy_bad;
        a        = ta;
        b        = tb;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_ready_wait"}, 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (out_valid !== 1'b1 && lat < 30) begin
            if (busy !== ((exp_lat == 9) ? 1'b1 : 1'b0)) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, 32'(result), 32'(expv));
        chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
        $display("op %s: a=%h b=%h result=%h expected=%h latency=%0d", tag, ta, tb, result, expv, lat);
        if (consume) begin
            @(posedge clk); #1;
            chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
            chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal path
        run_op("two_by_one",  8'h40, 8'h38, 8'h40, 9, 1'b0, 1'b1);
        run_op("one_by_1p5",  8'h38, 8'h3C, 8'h33, 9, 1'b0, 1'b1);
        run_op("neg_by_1p5",  8'hB8, 8'h3C, 8'hB3, 9, 1'b0, 1'b1);
        run_op("sat_pos",     8'h7F, 8'h08, 8'h7F, 9, 1'b0, 1'b1);
        run_op("sat_neg",     8'hFF, 8'h08, 8'hFF, 9, 1'b0, 1'b1);
        run_op("underflow",   8'h08, 8'h78, 8'h00, 9, 1'b0, 1'b1);
        run_op("round_up",    8'h3B, 8'h3A, 8'h39, 9, 1'b0, 1'b1);

        // Specials
        run_op("div_zero",    8'h38, 8'h00, 8'h80, 1, 1'b0, 1'b1);
        run_op("nan_a",       8'h80, 8'h38, 8'h80, 1, 1'b0, 1'b1);
        run_op("zero_by_nan", 8'h00, 8'h80, 8'h80, 1, 1'b0, 1'b1);
        run_op("zero_num",    8'h00, 8'h38, 8'h00, 1, 1'b0, 1'b1);

        // Result held while out_ready is low; new operands ignored
        out_ready = 1'b0;
        run_op("hold", 8'h3B, 8'h3A, 8'h39, 9, 1'b0, 1'b0);
        a        = 8'h40;
        b        = 8'h38;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(result), 32'h39);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_result_kept", 32'(result), 32'h39);
        $display("op hold: released after 5 stalled cycles, result=%h", result);

        // Asynchronous reset in the middle of DIV
        a        = 8'h40;
        b        = 8'h38;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", 32'(result), 32'h00);
        #3;
        rst_n = 1'b1;
        $display("op reset: aborted mid-DIV, result=%h", result);
        @(posedge clk); #1;
        chk("after_reset_valid", 32'(out_valid), 32'd0);

        // Back-to-back with in_valid held high
        run_op("b2b_0", 8'h3F, 8'h39, 8'h3D, 9, 1'b1, 1'b1);
        run_op("b2b_1", 8'h38, 8'h3C, 8'h33, 9, 1'b1, 1'b1);
        run_op("b2b_2", 8'h7F, 8'h08, 8'h7F, 9, 1'b1, 1'b1);
        run_op("b2b_3", 8'h00, 8'h38, 8'h00, 1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
